// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: multiply/divide sequencer owning the architectural HI/LO registers.
//
// A mult/multu/div/divu issued from the E stage computes its result on the start edge,
// parks it in pend_hi/pend_lo, and holds busy for MULT_CYCLES or DIV_CYCLES cycles before
// committing to HI/LO. mthi/mtlo write HI/LO immediately; mfhi/mflo read through md_rd.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     E-stage instruction valid and not flushed
//   md_op     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//             7 mfhi, 8 mflo, 9-15 none
//   a, b      forwarded rs / rt operands
//   d_is_md   D-stage instruction is a mult/div-unit op
//   busy      multi-cycle operation in progress
//   stall_md  freeze PC/ID and bubble EX
//   hi, lo    architectural HI / LO
//   md_rd     mfhi/mflo read data
module md_seq_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;

    logic is_mul_op;
    logic is_div_op;
    logic is_long_op;

    assign is_mul_op  = (md_op == OpMult) || (md_op == OpMultu);
    assign is_div_op  = (md_op == OpDiv) || (md_op == OpDivu);
    assign is_long_op = is_mul_op || is_div_op;

    // Result datapath
    logic [63:0] prod_s, prod_u;
    logic [31:0] b_safe, abs_a, abs_b;
    logic [31:0] quo_u, rem_u, quo_mag, rem_mag, quo_s, rem_s;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};
        // Divisor forced non-zero so the dividers never see 0; the b==0 result is discarded.
        b_safe  = (b == 32'd0) ? 32'd1 : b;
        abs_a   = a[31] ? (~a + 32'd1) : a;
        abs_b   = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
        quo_u   = a / b_safe;
        rem_u   = a % b_safe;
        // Signed divide via magnitudes: 0x80000000 / -1 naturally yields 0x80000000 rem 0.
        quo_mag = abs_a / abs_b;
        rem_mag = abs_a % abs_b;
        quo_s   = (a[31] ^ b_safe[31]) ? (~quo_mag + 32'd1) : quo_mag;
        rem_s   = a[31] ? (~rem_mag + 32'd1) : rem_mag;

        res_hi = hi_q;
        res_lo = lo_q;
        case (md_op)
            OpMult:  {res_hi, res_lo} = prod_s;
            OpMultu: {res_hi, res_lo} = prod_u;
            OpDiv: begin
                // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
                if (b != 32'd0) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OpDivu: begin
                if (b != 32'd0) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_long_op) begin
                        state_d   = StRun;
                        cnt_d     = is_mul_op ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                    end else if (md_op == OpMthi) begin
                        hi_d = a;
                    end else if (md_op == OpMtlo) begin
                        lo_d = a;
                    end
                end
            end
            StRun: begin
                // Any start seen here is ignored; stall_md keeps the pipeline from issuing one.
                if (cnt_q <= CntW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    // Outputs
    assign busy     = (state_q == StRun);
    // Gated by reset so the stall request is quiet while the block is held in reset.
    assign stall_md = reset & d_is_md & (busy | (start & is_long_op));
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        md_rd = 32'd0;
        if (md_op == OpMfhi) begin
            md_rd = hi_q;
        end else if (md_op == OpMflo) begin
            md_rd = lo_q;
        end
    end

endmodule
